// File: rtl/dnn_pkg.sv
// dnn_pkg
//   Shared constants, FSM state type and weight bank indices for the dnn
//   layer sequencer. Imported by dnn_wbank and dnn_seq_ctrl.
//   No ports (package).
package dnn_pkg;

  localparam int XW  = 7;   // signed input element width
  localparam int WW  = 5;   // signed weight width
  localparam int YW  = 21;  // datapath result width
  localparam int NW  = 24;  // number of weights in the bank
  localparam int AW  = 5;   // weight address width
  localparam int TMO = 4;   // WAIT cycles allowed before a timeout
  localparam int TCW = $clog2(TMO);

  typedef enum logic [2:0] {
    UNCFG = 3'd0,
    IDLE  = 3'd1,
    ISSUE = 3'd2,
    WAIT  = 3'd3,
    HOLD  = 3'd4
  } dnn_ctrl_state_t;

  // Bank address of each weight. wIJ connects node I to node J; the first
  // sixteen feed hidden lanes 4..7, the last eight feed outputs 8 and 9.
  localparam int W04 = 0;
  localparam int W05 = 1;
  localparam int W06 = 2;
  localparam int W07 = 3;
  localparam int W14 = 4;
  localparam int W15 = 5;
  localparam int W16 = 6;
  localparam int W17 = 7;
  localparam int W24 = 8;
  localparam int W25 = 9;
  localparam int W26 = 10;
  localparam int W27 = 11;
  localparam int W34 = 12;
  localparam int W35 = 13;
  localparam int W36 = 14;
  localparam int W37 = 15;
  localparam int W48 = 16;
  localparam int W58 = 17;
  localparam int W49 = 18;
  localparam int W59 = 19;
  localparam int W68 = 20;
  localparam int W69 = 21;
  localparam int W78 = 22;
  localparam int W79 = 23;

endpackage

// File: rtl/dnn_wbank.sv
// dnn_wbank
//   NW x WW weight register bank with a single write port and the whole
//   bank presented as one flattened read bus (index 0 in the LSBs).
//   Ports:
//     clk, rst_n  clock, asynchronous active-low reset (bank clears to 0)
//     we          write enable; caller guarantees waddr < NW when high
//     waddr       weight index
//     wdata       signed weight value
//     rd_bus      flattened bank contents
module dnn_wbank
  import dnn_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [WW-1:0]     wdata,
  output logic [NW*WW-1:0]  rd_bus
);

  logic [WW-1:0] bank [NW];

  // Weight storage: cleared by reset, one entry updated per accepted write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NW; i++) begin
        bank[i] <= '0;
      end
    end else if (we) begin
      bank[waddr] <= wdata;
    end
  end

  // Flatten the bank onto the read bus, entry 0 lowest.
  for (genvar g = 0; g < NW; g++) begin : g_flat
    assign rd_bus[g*WW +: WW] = bank[g];
  end

endmodule

// File: rtl/dnn_seq_ctrl.sv
// dnn_seq_ctrl
//   Sequencer and configuration controller for the 4-input / 4-hidden dnn
//   layer datapath. Holds the weight bank, issues one input vector per
//   handshake, waits for the datapath result with a timeout and holds the
//   result on a valid/ready port.
//   Ports:
//     clk, rst_n                 clock, asynchronous active-low reset
//     wl_valid/addr/data/ready   weight write port
//     cfg_commit                 marks the bank complete (UNCFG only)
//     in_valid/in_x/in_ready     input vector handshake, {x3,x2,x1,x0}
//     dp_x, dp_w                 registered vector and weight bank to datapath
//     dp_stg_1_rdy               issue strobe (one cycle, ISSUE state)
//     dp_stg_2_rdy, dp_y         result strobe and {y3,y2,y1,y0} from datapath
//     out_valid/out_y/out_ready  result handshake
//     busy                       state is not UNCFG/IDLE
//     err_addr, err_tmo          sticky error flags
//     inf_cnt                    completed inferences, 16-bit wrap
module dnn_seq_ctrl
  import dnn_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wl_valid,
  input  logic [AW-1:0]     wl_addr,
  input  logic [WW-1:0]     wl_data,
  output logic              wl_ready,
  input  logic              cfg_commit,
  input  logic              in_valid,
  input  logic [4*XW-1:0]   in_x,
  output logic              in_ready,
  output logic [4*XW-1:0]   dp_x,
  output logic [NW*WW-1:0]  dp_w,
  output logic              dp_stg_1_rdy,
  input  logic              dp_stg_2_rdy,
  input  logic [4*YW-1:0]   dp_y,
  output logic              out_valid,
  output logic [4*YW-1:0]   out_y,
  input  logic              out_ready,
  output logic              busy,
  output logic              err_addr,
  output logic              err_tmo,
  output logic [15:0]       inf_cnt
);

  dnn_ctrl_state_t state, next_state;
  logic [TCW-1:0]  tmo_cnt;
  logic            wr_fire;
  logic            addr_ok;
  logic            bank_we;
  logic            in_fire;
  logic            tmo_hit;

  assign wr_fire = wl_valid & wl_ready;
  assign addr_ok = (wl_addr < AW'(NW));
  assign bank_we = wr_fire & addr_ok;
  assign in_fire = in_valid & in_ready;
  assign tmo_hit = (state == WAIT) & ~dp_stg_2_rdy & (tmo_cnt == TCW'(TMO - 1));

  dnn_wbank u_wbank (
    .clk    (clk),
    .rst_n  (rst_n),
    .we     (bank_we),
    .waddr  (wl_addr),
    .wdata  (wl_data),
    .rd_bus (dp_w)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= UNCFG;
    end else begin
      state <= next_state;
    end
  end

  // Next-state decode. In IDLE any write, even to a bad address, drops the
  // committed configuration so the bank must be re-committed before use;
  // in UNCFG a write applies first and a same-cycle commit still moves on.
  always_comb begin
    next_state = state;
    case (state)
      UNCFG: if (cfg_commit) next_state = IDLE;
      IDLE: begin
        if (wl_valid)      next_state = UNCFG;
        else if (in_valid) next_state = ISSUE;
      end
      ISSUE: next_state = WAIT;
      WAIT: begin
        if (dp_stg_2_rdy) next_state = HOLD;
        else if (tmo_hit) next_state = IDLE;
      end
      HOLD: if (out_ready) next_state = IDLE;
      default: next_state = UNCFG;
    endcase
  end

  // Handshake and strobe decode. A pending write blocks input acceptance in
  // IDLE; wl_ready follows rst_n in UNCFG so nothing reports ready in reset.
  always_comb begin
    wl_ready     = 1'b0;
    in_ready     = 1'b0;
    dp_stg_1_rdy = 1'b0;
    case (state)
      UNCFG: wl_ready = rst_n;
      IDLE: begin
        wl_ready = 1'b1;
        in_ready = ~wl_valid;
      end
      ISSUE: dp_stg_1_rdy = 1'b1;
      default: ;
    endcase
  end

  // Registered datapath-facing and result-facing outputs, timeout counter,
  // sticky errors and the inference counter. busy is registered from the
  // next state so it lines up with the state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dp_x      <= '0;
      out_y     <= '0;
      out_valid <= 1'b0;
      tmo_cnt   <= '0;
      err_addr  <= 1'b0;
      err_tmo   <= 1'b0;
      inf_cnt   <= '0;
      busy      <= 1'b0;
    end else begin
      busy <= (next_state != UNCFG) && (next_state != IDLE);
      if (in_fire) begin
        dp_x <= in_x;
      end
      if (state == ISSUE) begin
        tmo_cnt <= '0;
      end else if ((state == WAIT) && !dp_stg_2_rdy && !tmo_hit) begin
        tmo_cnt <= tmo_cnt + 1'b1;
      end
      if ((state == WAIT) && dp_stg_2_rdy) begin
        out_y     <= dp_y;
        out_valid <= 1'b1;
      end
      if (tmo_hit) begin
        err_tmo <= 1'b1;
      end
      if ((state == HOLD) && out_ready) begin
        out_valid <= 1'b0;
        inf_cnt   <= inf_cnt + 16'd1;
      end
      if (wr_fire && !addr_ok) begin
        err_addr <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_dnn_seq_ctrl.sv
// tb_dnn_seq_ctrl
//   Directed bench for dnn_seq_ctrl. A small behavioural datapath answers
//   each issue strobe one cycle later with ReLU(sum x_i * w_ij) per lane,
//   and can be muted to provoke a timeout. Inputs are driven on the falling
//   edge; outputs are sampled on the falling edge after the active edge.
module tb_dnn_seq_ctrl;
  import dnn_pkg::*;

  logic              clk;
  logic              rst_n;
  logic              wl_valid;
  logic [AW-1:0]     wl_addr;
  logic [WW-1:0]     wl_data;
  logic              wl_ready;
  logic              cfg_commit;
  logic              in_valid;
  logic [4*XW-1:0]   in_x;
  logic              in_ready;
  logic [4*XW-1:0]   dp_x;
  logic [NW*WW-1:0]  dp_w;
  logic              dp_stg_1_rdy;
  logic              dp_stg_2_rdy;
  logic [4*YW-1:0]   dp_y;
  logic              out_valid;
  logic [4*YW-1:0]   out_y;
  logic              out_ready;
  logic              busy;
  logic              err_addr;
  logic              err_tmo;
  logic [15:0]       inf_cnt;

  int checkCount = 0;
  int failCount  = 0;
  logic preInReady, preWlReady, preStg1;
  logic stg2En;

  logic [NW*WW-1:0] bankOnes, bankNeg, bankMix;
  logic [4*XW-1:0]  xA, xOnes, xMix;
  logic [4*YW-1:0]  yTen, yMix;
  int mixTab [NW];

  dnn_seq_ctrl dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .wl_valid     (wl_valid),
    .wl_addr      (wl_addr),
    .wl_data      (wl_data),
    .wl_ready     (wl_ready),
    .cfg_commit   (cfg_commit),
    .in_valid     (in_valid),
    .in_x         (in_x),
    .in_ready     (in_ready),
    .dp_x         (dp_x),
    .dp_w         (dp_w),
    .dp_stg_1_rdy (dp_stg_1_rdy),
    .dp_stg_2_rdy (dp_stg_2_rdy),
    .dp_y         (dp_y),
    .out_valid    (out_valid),
    .out_y        (out_y),
    .out_ready    (out_ready),
    .busy         (busy),
    .err_addr     (err_addr),
    .err_tmo      (err_tmo),
    .inf_cnt      (inf_cnt)
  );

  // 10 ns clock, rising edges at 5, 15, 25 ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Behavioural datapath: lane j = ReLU(sum_i x_i * w[i*4+j]).
  function automatic logic [4*YW-1:0] modelY(input logic [4*XW-1:0] x,
                                              input logic [NW*WW-1:0] w);
    logic [4*YW-1:0] y;
    int acc;
    y = '0;
    for (int j = 0; j < 4; j++) begin
      acc = 0;
      for (int i = 0; i < 4; i++) begin
        acc = acc + int'($signed(x[i*XW +: XW])) * int'($signed(w[(i*4+j)*WW +: WW]));
      end
      if (acc > 0) y[j*YW +: YW] = YW'(acc);
    end
    return y;
  endfunction

  assign dp_y = modelY(dp_x, dp_w);

  // Result strobe one cycle after the issue strobe, unless muted.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) dp_stg_2_rdy <= 1'b0;
    else        dp_stg_2_rdy <= dp_stg_1_rdy & stg2En;
  end

  // Overall time bound.
  initial begin
    #50000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [127:0] observed,
                             input logic [127:0] expected);
    checkCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Drive one cycle of inputs, record the decoded handshakes just before the
  // active edge, then return to idle inputs on the following falling edge.
  task automatic applyStimulus(input logic wv, input logic [AW-1:0] wa,
                               input logic [WW-1:0] wd, input logic cc,
                               input logic iv, input logic [4*XW-1:0] x,
                               input logic ordy);
    wl_valid   = wv;
    wl_addr    = wa;
    wl_data    = wd;
    cfg_commit = cc;
    in_valid   = iv;
    in_x       = x;
    out_ready  = ordy;
    #1;
    preInReady = in_ready;
    preWlReady = wl_ready;
    preStg1    = dp_stg_1_rdy;
    @(negedge clk);
    wl_valid   = 1'b0;
    wl_addr    = '0;
    wl_data    = '0;
    cfg_commit = 1'b0;
    in_valid   = 1'b0;
    in_x       = '0;
    out_ready  = 1'b0;
  endtask

  task automatic idleCycle();
    applyStimulus(1'b0, '0, '0, 1'b0, 1'b0, '0, 1'b0);
  endtask

  // Load the whole bank, committing in the same cycle as the last write.
  task automatic writeBank(input logic [NW*WW-1:0] bankVal);
    for (int a = 0; a < NW; a++) begin
      applyStimulus(1'b1, AW'(a), bankVal[a*WW +: WW], (a == NW-1), 1'b0, '0, 1'b0);
    end
  endtask

  task automatic checkAllZero(input string when);
    checkOutput({when, "_out_valid"}, 128'(out_valid), 128'd0);
    checkOutput({when, "_out_y"},     128'(out_y),     128'd0);
    checkOutput({when, "_dp_x"},      128'(dp_x),      128'd0);
    checkOutput({when, "_dp_w"},      128'(dp_w),      128'd0);
    checkOutput({when, "_busy"},      128'(busy),      128'd0);
    checkOutput({when, "_err_addr"},  128'(err_addr),  128'd0);
    checkOutput({when, "_err_tmo"},   128'(err_tmo),   128'd0);
    checkOutput({when, "_inf_cnt"},   128'(inf_cnt),   128'd0);
    checkOutput({when, "_in_ready"},  128'(in_ready),  128'd0);
    checkOutput({when, "_wl_ready"},  128'(wl_ready),  128'd0);
    checkOutput({when, "_stg1"},      128'(dp_stg_1_rdy), 128'd0);
  endtask

  initial begin
    stg2En     = 1'b1;
    wl_valid   = 1'b0;
    wl_addr    = '0;
    wl_data    = '0;
    cfg_commit = 1'b0;
    in_valid   = 1'b0;
    in_x       = '0;
    out_ready  = 1'b0;

    mixTab = '{2, -1, 15, 0,   -3, -1, 15, -1,   1, -1, 15, 0,   0, -1, 15, -16,
               16, 17, 18, 19, 20, 21, 22, 23};
    for (int i = 0; i < NW; i++) begin
      bankOnes[i*WW +: WW] = 5'd1;
      bankNeg[i*WW +: WW]  = (i < 16 && (i % 4) == 0) ? 5'h1F : 5'h00;
      bankMix[i*WW +: WW]  = 5'(mixTab[i]);
    end
    xA    = {7'd4, 7'd3, 7'd2, 7'd1};
    xOnes = {7'd1, 7'd1, 7'd1, 7'd1};
    xMix  = {7'h7F, 7'd5, 7'h40, 7'd63};
    yTen  = {21'd10, 21'd10, 21'd10, 21'd10};
    yMix  = {21'd80, 21'd45, 21'd0, 21'd323};

    // Reset values.
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #1 checkAllZero("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // All weights 1, x = 1..4, every lane 10.
    writeBank(bankOnes);
    checkOutput("t1_dp_w", 128'(dp_w), 128'(bankOnes));
    checkOutput("t1_busy_idle", 128'(busy), 128'd0);
    applyStimulus(1'b0, '0, '0, 1'b0, 1'b1, xA, 1'b0);
    checkOutput("t1_in_ready", 128'(preInReady), 128'd1);
    checkOutput("t1_wl_ready", 128'(preWlReady), 128'd1);
    checkOutput("t1_dp_x", 128'(dp_x), 128'(xA));
    checkOutput("t1_busy", 128'(busy), 128'd1);
    checkOutput("t1_stg1", 128'(dp_stg_1_rdy), 128'd1);
    idleCycle();
    checkOutput("t1_valid_e1", 128'(out_valid), 128'd0);
    checkOutput("t1_stg1_off", 128'(dp_stg_1_rdy), 128'd0);
    idleCycle();
    checkOutput("t1_valid_e2", 128'(out_valid), 128'd1);
    checkOutput("t1_out_y", 128'(out_y), 128'(yTen));
    applyStimulus(1'b0, '0, '0, 1'b0, 1'b0, '0, 1'b1);
    checkOutput("t1_hold_in_ready", 128'(preInReady), 128'd0);
    checkOutput("t1_valid_clr", 128'(out_valid), 128'd0);
    checkOutput("t1_inf_cnt", 128'(inf_cnt), 128'd1);

    // Lane-0 weights -1, others 0, x all 1: ReLU clamps everything to 0.
    writeBank(bankNeg);
    checkOutput("t2_dp_w_lane0", 128'(dp_w[W04*WW +: WW]), 128'h1F);
    checkOutput("t2_dp_w_w79", 128'(dp_w[W79*WW +: WW]), 128'h00);
    applyStimulus(1'b0, '0, '0, 1'b0, 1'b1, xOnes, 1'b0);
    idleCycle();
    idleCycle();
    checkOutput("t2_valid", 128'(out_valid), 128'd1);
    checkOutput("t2_out_y", 128'(out_y), 128'd0);
    applyStimulus(1'b0, '0, '0, 1'b0, 1'b0, '0, 1'b1);
    checkOutput("t2_inf_cnt", 128'(inf_cnt), 128'd2);

    // Mixed weights with backpressure.
    writeBank(bankMix);
    checkOutput("t3_dp_w", 128'(dp_w), 128'(bankMix));
    applyStimulus(1'b0, '0, '0, 1'b0, 1'b1, xMix, 1'b0);
    idleCycle();
    idleCycle();
    checkOutput("t3_out_y", 128'(out_y), 128'(yMix));
    for (int c = 0; c < 5; c++) begin
      applyStimulus(1'b0, '0, '0, 1'b0, 1'b1, xA, 1'b0);
      checkOutput("t3_bp_in_ready", 128'(preInReady), 128'd0);
      checkOutput("t3_bp_out_y", 128'(out_y), 128'(yMix));
      checkOutput("t3_bp_valid", 128'(out_valid), 128'd1);
      checkOutput("t3_bp_dp_x", 128'(dp_x), 128'(xMix));
    end
    applyStimulus(1'b0, '0, '0, 1'b0, 1'b1, xA, 1'b1);
    checkOutput("t3_release_in_ready", 128'(preInReady), 128'd0);
    checkOutput("t3_inf_cnt", 128'(inf_cnt), 128'd3);
    checkOutput("t3_release_busy", 128'(busy), 128'd0);
    applyStimulus(1'b0, '0, '0, 1'b0, 1'b1, xMix, 1'b0);
    checkOutput("t3_resume_in_ready", 128'(preInReady), 128'd1);
    checkOutput("t3_resume_busy", 128'(busy), 128'd1);
    idleCycle();
    idleCycle();
    checkOutput("t3_resume_out_y", 128'(out_y), 128'(yMix));
    applyStimulus(1'b0, '0, '0, 1'b0, 1'b0, '0, 1'b1);
    checkOutput("t3_resume_inf_cnt", 128'(inf_cnt), 128'd4);

    // Out-of-range write in IDLE.
    applyStimulus(1'b1, 5'd24, 5'h0A, 1'b0, 1'b0, '0, 1'b0);
    checkOutput("t4_wl_ready", 128'(preWlReady), 128'd1);
    checkOutput("t4_err_addr", 128'(err_addr), 128'd1);
    checkOutput("t4_bank_kept", 128'(dp_w), 128'(bankMix));
    applyStimulus(1'b0, '0, '0, 1'b0, 1'b1, xA, 1'b0);
    checkOutput("t4_uncfg_in_ready", 128'(preInReady), 128'd0);
    checkOutput("t4_uncfg_busy", 128'(busy), 128'd0);
    checkOutput("t4_uncfg_dp_x", 128'(dp_x), 128'(xMix));
    applyStimulus(1'b0, '0, '0, 1'b1, 1'b0, '0, 1'b0);

    // Silent datapath: timeout after TMO WAIT cycles.
    stg2En = 1'b0;
    applyStimulus(1'b0, '0, '0, 1'b0, 1'b1, xA, 1'b0);
    checkOutput("t5_in_ready", 128'(preInReady), 128'd1);
    checkOutput("t5_dp_x", 128'(dp_x), 128'(xA));
    idleCycle();
    for (int c = 0; c < TMO - 1; c++) begin
      idleCycle();
      checkOutput("t5_wait_busy", 128'(busy), 128'd1);
      checkOutput("t5_wait_err_tmo", 128'(err_tmo), 128'd0);
    end
    idleCycle();
    checkOutput("t5_err_tmo", 128'(err_tmo), 128'd1);
    checkOutput("t5_busy", 128'(busy), 128'd0);
    checkOutput("t5_out_valid", 128'(out_valid), 128'd0);
    checkOutput("t5_inf_cnt", 128'(inf_cnt), 128'd4);
    checkOutput("t5_err_addr_sticky", 128'(err_addr), 128'd1);
    applyStimulus(1'b0, '0, '0, 1'b0, 1'b1, xOnes, 1'b0);
    checkOutput("t5_idle_in_ready", 128'(preInReady), 128'd1);

    // Reset asserted in WAIT.
    idleCycle();
    checkOutput("t6_in_wait", 128'(busy), 128'd1);
    #2 rst_n = 1'b0;
    #1 checkAllZero("t6_reset");
    @(negedge clk);
    rst_n  = 1'b1;
    stg2En = 1'b1;
    applyStimulus(1'b0, '0, '0, 1'b0, 1'b1, xA, 1'b0);
    checkOutput("t6_uncfg_in_ready", 128'(preInReady), 128'd0);
    checkOutput("t6_uncfg_busy", 128'(busy), 128'd0);
    applyStimulus(1'b0, '0, '0, 1'b1, 1'b0, '0, 1'b0);
    applyStimulus(1'b0, '0, '0, 1'b0, 1'b1, xA, 1'b0);
    checkOutput("t6_commit_in_ready", 128'(preInReady), 128'd1);
    checkOutput("t6_commit_busy", 128'(busy), 128'd1);
    checkOutput("t6_bank_zero", 128'(dp_w), 128'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
    $finish;
  end

endmodule
